// File: rtl/mdu_iter_if.sv
// rtl/mdu_iter_if.sv - pipeline-side bundle for the iterative multiply/divide unit
interface mdu_iter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - radix-2 iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  mdu_iter_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             op_div;
  logic             neg_lo;
  logic             neg_hi;
  logic             divz;
  logic [WIDTH-1:0] ph;
  logic [WIDTH-1:0] pl;
  logic [WIDTH-1:0] mb;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic             is_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   msum;
  logic [WIDTH:0]   dshift;
  logic [WIDTH:0]   ddiff;
  logic             ge;
  logic [WIDTH-1:0] rem_next;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign is_signed = ~bus.op[0];
  assign a_neg     = is_signed & bus.a[WIDTH-1];
  assign b_neg     = is_signed & bus.b[WIDTH-1];
  assign a_mag     = a_neg ? (~bus.a + 1'b1) : bus.a;
  assign b_mag     = b_neg ? (~bus.b + 1'b1) : bus.b;

  // Multiply: {ph,pl} holds partial product over the shrinking multiplier.
  assign msum = {1'b0, ph} + {1'b0, (pl[0] ? mb : {WIDTH{1'b0}})};

  // Divide: partial remainder stays below the divisor, so the sign bit of ddiff is a valid compare.
  assign dshift   = {ph, pl[WIDTH-1]};
  assign ddiff    = dshift - {1'b0, mb};
  assign ge       = ~ddiff[WIDTH];
  assign rem_next = ge ? ddiff[WIDTH-1:0] : dshift[WIDTH-1:0];

  assign prod     = {ph, pl};
  assign prod_fix = neg_lo ? (~prod + 1'b1) : prod;
  // A zero divisor leaves quotient all ones and remainder equal to the dividend.
  assign q_fix    = (neg_lo && !divz) ? (~pl + 1'b1) : pl;
  assign r_fix    = neg_hi ? (~ph + 1'b1) : ph;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      op_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      divz   <= 1'b0;
      ph     <= '0;
      pl     <= '0;
      mb     <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.hi_we) hi_q <= bus.wdata;
          if (bus.lo_we) lo_q <= bus.wdata;
          if (bus.start) begin
            state  <= RUN;
            busy_q <= 1'b1;
            cnt    <= '0;
            op_div <= bus.op[1];
            neg_lo <= a_neg ^ b_neg;
            neg_hi <= a_neg;
            divz   <= (bus.b == '0);
            ph     <= '0;
            if (bus.op[1]) begin
              pl <= a_mag;
              mb <= b_mag;
            end else begin
              pl <= b_mag;
              mb <= a_mag;
            end
          end
        end
        RUN: begin
          if (op_div) begin
            ph <= rem_next;
            pl <= {pl[WIDTH-2:0], ge};
          end else begin
            ph <= msum[WIDTH:1];
            pl <= {msum[0], pl[WIDTH-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          if (op_div) begin
            hi_q <= r_fix;
            lo_q <= q_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - directed vector bench for mdu_iter at WIDTH=32
module tb_mdu_iter;
  localparam int W = 32;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  mdu_iter_if #(.WIDTH(W)) bus ();

  mdu_iter #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at posedge+1 while idle; returns the edge count from E0 (inclusive) until done is seen.
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int lat);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = ~op;
    bus.a     = ~a;
    bus.b     = b ^ 32'h5A5A_0001;
    lat = 1;
    chk({name, " busy_after_e0"}, 32'(bus.busy), 32'd1);
    while (!bus.done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({name, " busy_in_done"}, 32'(bus.busy), 32'd0);
  endtask

  int lat;
  int seen;

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;

    vecs[0]  = '{"mult_neg1x2",   2'b00, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[1]  = '{"multu_max_x2",  2'b01, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
    vecs[2]  = '{"multu_maxsq",   2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[3]  = '{"div_m7_2",      2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4]  = '{"divu_7_2",      2'b11, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
    vecs[5]  = '{"div_min_m1",    2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[6]  = '{"divu_by0",      2'b11, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};
    vecs[7]  = '{"div_7_m2",      2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[8]  = '{"mult_3_m5",     2'b00, 32'h00000003, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[9]  = '{"div_m7_by0",    2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[10] = '{"multu_2p16sq",  2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
    vecs[11] = '{"divu_100_10",   2'b11, 32'h00000064, 32'h0000000A, 32'h00000000, 32'h0000000A};

    #12;
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset hi", bus.hi, 32'h0);
    chk("reset lo", bus.lo, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, lat);
      chk({vecs[i].name, " latency"}, 32'(lat), 32'd34);
      chk({vecs[i].name, " hi"}, bus.hi, vecs[i].exp_hi);
      chk({vecs[i].name, " lo"}, bus.lo, vecs[i].exp_lo);
      @(posedge clk);
      #1;
      chk({vecs[i].name, " done_one_cycle"}, 32'(bus.done), 32'd0);
    end

    // MTHI after a divide-by-zero result: HI replaced, LO kept.
    run_op("divu_by0_b", 2'b11, 32'h12345678, 32'h0, lat);
    bus.hi_we = 1'b1;
    bus.wdata = 32'h0000BEEF;
    @(posedge clk);
    #1;
    bus.hi_we = 1'b0;
    chk("mthi hi", bus.hi, 32'h0000BEEF);
    chk("mthi lo", bus.lo, 32'hFFFFFFFF);

    // Start and MTLO while busy are ignored; then a start in the done cycle is accepted.
    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.a     = 32'd7;
    bus.b     = 32'd6;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.op    = 2'b10;
    bus.a     = 32'd99;
    bus.b     = 32'd3;
    bus.lo_we = 1'b1;
    bus.wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.lo_we = 1'b0;
    lat = 6;
    while (!bus.done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("busy_ignore latency", 32'(lat), 32'd34);
    chk("busy_ignore lo", bus.lo, 32'h0000002A);
    chk("busy_ignore hi", bus.hi, 32'h0);
    run_op("b2b_divu", 2'b11, 32'd100, 32'd7, lat);
    chk("b2b_divu latency", 32'(lat), 32'd34);
    chk("b2b_divu lo", bus.lo, 32'h0000000E);
    chk("b2b_divu hi", bus.hi, 32'h00000002);

    // Reset mid-RUN aborts the divide.
    bus.start = 1'b1;
    bus.op    = 2'b10;
    bus.a     = 32'd1000;
    bus.b     = 32'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort busy", 32'(bus.busy), 32'd0);
    chk("abort hi", bus.hi, 32'h0);
    chk("abort lo", bus.lo, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < W + 6; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) seen++;
    end
    chk("abort no_done", 32'(seen), 32'd0);
    run_op("mult_3_5", 2'b00, 32'd3, 32'd5, lat);
    chk("mult_3_5 latency", 32'(lat), 32'd34);
    chk("mult_3_5 lo", bus.lo, 32'h0000000F);
    chk("mult_3_5 hi", bus.hi, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
